pred_multi: RTL and testbench
=============================

PRED_MULTI -- requirements
Module: pred_multi

Interface
REQ-001 Parameter CH, default 4: number of independent edge-delay channels, range 1..8.
REQ-002 Parameter DW, default 8: width of delay values and of the write data bus; DW SHALL be >= CH.
REQ-003 Parameter AW, default 4: width of the register address bus.
REQ-004 Parameter ADDR_BASE, default 4: address of the first delay register; ADDR_BASE+2*CH SHALL fit in AW bits.
REQ-005 Parameter DEFAULT_SHIFT, default 0: reset value of every delay register.
REQ-006 clk  in  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 sgn  in  CH  asynchronous input signals, one bit per channel.
REQ-009 shift  in  DW  register write data.
REQ-010 addr  in  AW  register write address.
REQ-011 en  in  1  write strobe; a write occurs on any clock with en=1.
REQ-012 sgn_pre  out  CH  delayed copy of each channel's input.
REQ-013 busy  out  CH  1 while the channel has a pending edge.

Function
REQ-014 Register map: ADDR_BASE+2k = rise delay of channel k; ADDR_BASE+2k+1 = fall delay of channel k; ADDR_BASE+2*CH = control register, where bit k = bypass for channel k. Writes to other addresses SHALL be ignored.
REQ-015 Each sgn bit SHALL pass through a 2-flop synchronizer (s_k) before any use.
REQ-016 Per-channel FSM states: IDLE (s_k == sgn_pre[k]) and PEND (edge awaiting release).
REQ-017 IDLE with s_k != sgn_pre[k] and selected delay D = 0: sgn_pre[k] SHALL take s_k on the next clock; state stays IDLE.
REQ-018 IDLE with s_k != sgn_pre[k] and D > 0: cnt SHALL load D-1 and the FSM SHALL go to PEND. D is the rise delay if s_k = 1, otherwise the fall delay.
REQ-019 PEND with s_k == sgn_pre[k] (input reverted): the edge SHALL be cancelled, cnt cleared, FSM to IDLE, and sgn_pre unchanged.
REQ-020 PEND with cnt = 0: sgn_pre[k] SHALL take s_k and the FSM SHALL go to IDLE; otherwise cnt SHALL decrement by 1.
REQ-021 Latency from a sgn edge to the sgn_pre edge SHALL be exactly D+3 clocks: 2 for synchronization plus D+1.
REQ-022 The delay is captured at load: a register write during PEND SHALL affect only later edges.
REQ-023 Bypass=1: sgn_pre[k] SHALL equal s_k registered (latency 3), with the FSM held in IDLE and busy[k]=0. Setting bypass during PEND SHALL cancel the pending edge.
REQ-024 Input pulses shorter than D+1 synchronized clocks SHALL be suppressed entirely (glitch rejection).
REQ-025 busy[k] SHALL be 1 exactly while the FSM is in PEND.
REQ-026 cnt SHALL be DW bits wide, SHALL never wrap, and SHALL support D = 2^DW-1.
REQ-027 Channels SHALL be fully independent; simultaneous edges on all channels SHALL each meet REQ-021.

Reset
REQ-028 On rst=1 at a clock edge: synchronizer flops = 0, sgn_pre = 0, busy = 0, cnt = 0, FSM = IDLE, delay registers = DEFAULT_SHIFT, bypass = 0.
REQ-029 rst asserted during PEND SHALL discard the pending edge with no output glitch.
REQ-030 rst SHALL take priority over en writes in the same cycle.

Structure
REQ-031 A shared package pred_pkg SHALL hold the FSM state enum and the address-offset constants (rise=0, fall=1, stride=2, control=2*CH).
REQ-032 Sub-module pred_ch SHALL implement one channel (synchronizer, FSM, counter); pred_multi SHALL instantiate it CH times and own the register file and address decode.

Verification
REQ-033 Write rise=5 for ch0, raise sgn[0] -> sgn_pre[0] rises exactly 8 clocks later; busy[0]=1 for 5 clocks.
REQ-034 Write rise=0 and fall=0 -> sgn_pre follows sgn with 3-clock latency on both edges.
REQ-035 rise=10, sgn[1] high for 4 clocks then low -> sgn_pre[1] stays 0; busy[1] drops when the reverted input is seen.
REQ-036 Rise edges on ch0..ch3 with rise delays 1,2,3,4 in the same cycle -> outputs rise at +4, +5, +6, +7 clocks.
REQ-037 rise=20 pending, rst pulsed at clock 10 -> sgn_pre=0, busy=0 next clock; delay register = DEFAULT_SHIFT.
REQ-038 rise=255 (DW=8) -> edge released at +258 clocks; bypass set on ch2 mid-PEND -> edge cancelled, then 3-clock pass-through.

Source files
------------

// File: rtl/pred_pkg.sv
// Shared types and register-map offsets for the multi-channel edge delay block.
package pred_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } ch_state_e;

    localparam int OFF_RISE = 0;
    localparam int OFF_FALL = 1;
    localparam int STRIDE   = 2;

    // The control register sits right after the last per-channel pair.
    function automatic int ctrl_off(input int ch);
        return STRIDE * ch;
    endfunction

endpackage

// File: rtl/pred_multi_if.sv
// Register-write bus plus per-channel signal inputs and delayed outputs.
interface pred_multi_if #(
    parameter int CH = 4,
    parameter int DW = 8,
    parameter int AW = 4
);
    logic [CH-1:0] sgn;
    logic [DW-1:0] shift;
    logic [AW-1:0] addr;
    logic          en;
    logic [CH-1:0] sgn_pre;
    logic [CH-1:0] busy;

    modport master (
        output sgn,
        output shift,
        output addr,
        output en,
        input  sgn_pre,
        input  busy
    );

    modport slave (
        input  sgn,
        input  shift,
        input  addr,
        input  en,
        output sgn_pre,
        output busy
    );
endinterface

// File: rtl/pred_ch.sv
// One edge-delay channel: 2-flop synchronizer, IDLE/PEND FSM and delay counter.
module pred_ch
    import pred_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sgn_i,
    input  logic          bypass_i,
    input  logic [DW-1:0] rise_i,
    input  logic [DW-1:0] fall_i,
    output logic          sgn_pre_o,
    output logic          busy_o
);

    logic [1:0]    sync_q;
    logic          pre_q;
    logic [DW-1:0] cnt_q;
    ch_state_e     state_q;
    logic          s;
    logic [DW-1:0] dly;

    assign s   = sync_q[1];
    assign dly = s ? rise_i : fall_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b00;
            pre_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            sync_q <= {sync_q[0], sgn_i};
            if (bypass_i) begin
                // Bypass drops any pending edge and follows the synced input.
                pre_q   <= s;
                cnt_q   <= '0;
                state_q <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (s != pre_q) begin
                            if (dly == '0) begin
                                pre_q <= s;
                            end else begin
                                cnt_q   <= dly - 1'b1;
                                state_q <= PEND;
                            end
                        end
                    end
                    PEND: begin
                        if (s == pre_q) begin
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else if (cnt_q == '0) begin
                            pre_q   <= s;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign sgn_pre_o = pre_q;
    assign busy_o    = (state_q == PEND);

endmodule

// File: rtl/pred_multi.sv
// Multi-channel edge delay: register file, address decode and CH channel instances.
module pred_multi
    import pred_pkg::*;
#(
    parameter int CH            = 4,
    parameter int DW            = 8,
    parameter int AW            = 4,
    parameter int ADDR_BASE     = 4,
    parameter int DEFAULT_SHIFT = 0
) (
    input logic         clk,
    input logic         rst,
    pred_multi_if.slave bus
);

    localparam logic [AW-1:0] CTRL_ADDR = AW'(ADDR_BASE + ctrl_off(CH));

    logic [DW-1:0] rise_q [CH];
    logic [DW-1:0] fall_q [CH];
    logic [CH-1:0] byp_q;
    logic [CH-1:0] pre;
    logic [CH-1:0] bsy;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                rise_q[k] <= DW'(DEFAULT_SHIFT);
                fall_q[k] <= DW'(DEFAULT_SHIFT);
            end
            byp_q <= '0;
        end else if (bus.en) begin
            for (int k = 0; k < CH; k++) begin
                if (bus.addr == AW'(ADDR_BASE + STRIDE * k + OFF_RISE))
                    rise_q[k] <= bus.shift;
                if (bus.addr == AW'(ADDR_BASE + STRIDE * k + OFF_FALL))
                    fall_q[k] <= bus.shift;
            end
            if (bus.addr == CTRL_ADDR)
                byp_q <= bus.shift[CH-1:0];
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        pred_ch #(
            .DW(DW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .sgn_i     (bus.sgn[k]),
            .bypass_i  (byp_q[k]),
            .rise_i    (rise_q[k]),
            .fall_i    (fall_q[k]),
            .sgn_pre_o (pre[k]),
            .busy_o    (bsy[k])
        );
    end

    assign bus.sgn_pre = pre;
    assign bus.busy    = bsy;

endmodule

// File: tb/tb_pred_multi.sv
// Directed bench for pred_multi with an edge-event scoreboard.
module tb_pred_multi;

    typedef struct {
        int   cyc;
        int   ch;
        logic val;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   chk = 0;
    int   fails = 0;
    logic [3:0] prev;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    pred_multi_if #(.CH(4), .DW(8), .AW(4)) bus ();

    pred_multi #(
        .CH(4), .DW(8), .AW(4), .ADDR_BASE(4), .DEFAULT_SHIFT(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++)
                if (bus.sgn_pre[k] !== prev[k])
                    obs_q.push_back('{cyc, k, bus.sgn_pre[k]});
        end
        prev <= bus.sgn_pre;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        chk++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int ch, input logic v, input int at);
        exp_q.push_back('{at, ch, v});
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        bus.en    = 1'b1;
        bus.addr  = a;
        bus.shift = d;
        @(negedge clk);
        bus.en    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag, input int budget);
        int t0;
        ev_t e;
        ev_t o;
        t0 = cyc;
        while (obs_q.size() < exp_q.size() && (cyc - t0) < budget)
            @(negedge clk);
        idle(2);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_ch"}, o.ch, e.ch);
            check({tag, "_val"}, int'(o.val), int'(e.val));
            check({tag, "_cyc"}, o.cyc, e.cyc);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int c;
        int n;
        int hi;
        rst       = 1'b1;
        bus.sgn   = '0;
        bus.shift = '0;
        bus.addr  = '0;
        bus.en    = 1'b0;
        idle(3);
        check("rst_pre", int'(bus.sgn_pre), 0);
        check("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        idle(2);

        // rise=5 on ch0: edge after 8 clocks, busy for 5
        wr(4'd4, 8'd5);
        c = cyc;
        bus.sgn[0] = 1'b1;
        push(0, 1'b1, c + 8);
        hi = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy[0]) hi++;
        end
        check("busy0_len", hi, 5);
        drain("rise5", 20);
        c = cyc;
        bus.sgn[0] = 1'b0;
        push(0, 1'b0, c + 3);
        drain("fall0", 20);

        // zero delay: 3-clock latency on both edges
        wr(4'd6, 8'd0);
        wr(4'd7, 8'd0);
        c = cyc;
        bus.sgn[1] = 1'b1;
        push(1, 1'b1, c + 3);
        idle(6);
        c = cyc;
        bus.sgn[1] = 1'b0;
        push(1, 1'b0, c + 3);
        drain("zero", 20);

        // glitch rejection: rise=10, 4-clock pulse
        wr(4'd6, 8'd10);
        c = cyc;
        bus.sgn[1] = 1'b1;
        idle(4);
        bus.sgn[1] = 1'b0;
        while (cyc < c + 6) @(negedge clk);
        check("glitch_busy_hi", int'(bus.busy[1]), 1);
        @(negedge clk);
        check("glitch_busy_lo", int'(bus.busy[1]), 0);
        idle(20);
        check("glitch_events", obs_q.size(), 0);
        check("glitch_pre", int'(bus.sgn_pre[1]), 0);
        obs_q.delete();

        // simultaneous rises, delays 1..4; ch3 fall=2
        wr(4'd4, 8'd1);
        wr(4'd6, 8'd2);
        wr(4'd8, 8'd3);
        wr(4'd10, 8'd4);
        wr(4'd11, 8'd2);
        c = cyc;
        bus.sgn = 4'hF;
        for (int k = 0; k < 4; k++) push(k, 1'b1, c + 4 + k);
        drain("multi_rise", 20);
        c = cyc;
        bus.sgn = 4'h0;
        for (int k = 0; k < 3; k++) push(k, 1'b0, c + 3);
        push(3, 1'b0, c + 5);
        drain("multi_fall", 20);

        // reset during PEND, colliding with a write
        wr(4'd4, 8'd20);
        c = cyc;
        bus.sgn[0] = 1'b1;
        while (cyc < c + 10) @(negedge clk);
        check("pend_busy", int'(bus.busy[0]), 1);
        rst       = 1'b1;
        bus.en    = 1'b1;
        bus.addr  = 4'd4;
        bus.shift = 8'd7;
        @(negedge clk);
        bus.en = 1'b0;
        check("rstp_pre", int'(bus.sgn_pre), 0);
        check("rstp_busy", int'(bus.busy), 0);
        rst = 1'b0;
        n = cyc;
        push(0, 1'b1, n + 3);
        drain("after_rst", 20);
        c = cyc;
        bus.sgn[0] = 1'b0;
        push(0, 1'b0, c + 3);
        drain("after_rst_fall", 20);

        // max delay on ch2, then bypass mid-PEND
        wr(4'd8, 8'd255);
        c = cyc;
        bus.sgn[2] = 1'b1;
        push(2, 1'b1, c + 258);
        drain("max", 300);
        c = cyc;
        bus.sgn[2] = 1'b0;
        push(2, 1'b0, c + 3);
        drain("max_fall", 20);
        bus.sgn[2] = 1'b1;
        idle(10);
        check("byp_pend", int'(bus.busy[2]), 1);
        n = cyc;
        wr(4'd12, 8'h04);
        push(2, 1'b1, n + 2);
        drain("byp_cancel", 20);
        check("byp_busy", int'(bus.busy[2]), 0);
        c = cyc;
        bus.sgn[2] = 1'b0;
        push(2, 1'b0, c + 3);
        drain("byp_fall", 20);
        c = cyc;
        bus.sgn[2] = 1'b1;
        push(2, 1'b1, c + 3);
        drain("byp_rise", 20);
        check("byp_busy2", int'(bus.busy[2]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
        $finish;
    end

endmodule
